// File: rtl/pos_xfer_if.sv
`timescale 1ns/1ps
// Position-transfer bundle: two position sources in, toggle req/ack crossing and status out.
// The slave modport is the controller's view; the master modport is the surrounding logic's view.
interface pos_xfer_if #(
  parameter int W = 12
);
  logic         src0_valid;
  logic [W-1:0] src0_x;
  logic [W-1:0] src0_y;
  logic         src1_valid;
  logic [W-1:0] src1_x;
  logic [W-1:0] src1_y;
  logic         ack_tgl;
  logic         req_tgl;
  logic [W-1:0] xpos_out;
  logic [W-1:0] ypos_out;
  logic         src_sel;
  logic         busy;
  logic [7:0]   drop_cnt;
  logic         timeout_err;

  modport slave (
    input  src0_valid, src0_x, src0_y, src1_valid, src1_x, src1_y, ack_tgl,
    output req_tgl, xpos_out, ypos_out, src_sel, busy, drop_cnt, timeout_err
  );

  modport master (
    output src0_valid, src0_x, src0_y, src1_valid, src1_x, src1_y, ack_tgl,
    input  req_tgl, xpos_out, ypos_out, src_sel, busy, drop_cnt, timeout_err
  );
endinterface

// File: rtl/pos_xfer_ctrl.sv
`timescale 1ns/1ps
// Round-robin scheduler of two position sources into a toggle req/ack crossing toward 40 MHz.
// Valid at edge E: outputs at E+2, req_tgl at E+3; no backpressure, a newer pending update overwrites and is counted.
module pos_xfer_ctrl #(
  parameter int W           = 12,
  parameter int TIMEOUT     = 64,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk100MHz,
  input  logic       rst,
  pos_xfer_if.slave  bus
);
  localparam int TMAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST    = TW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT_ACK, HOLD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    pend_q, pend_d;
  logic [W-1:0]  pend_x0_q, pend_x0_d, pend_y0_q, pend_y0_d;
  logic [W-1:0]  pend_x1_q, pend_x1_d, pend_y1_q, pend_y1_d;
  logic          grant_q, grant_d, last_grant_q, last_grant_d;
  logic [W-1:0]  xpos_q, xpos_d, ypos_q, ypos_d;
  logic          src_sel_q, src_sel_d, req_q, req_d;
  logic          busy_q, busy_d, terr_q, terr_d;
  logic          ack_s1_q, ack_s1_d, ack_s_q, ack_s_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    drop_q, drop_d;
  logic          consume0, consume1, drop0, drop1;
  logic [8:0]    drop_sum;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_x0_d    = pend_x0_q;
    pend_y0_d    = pend_y0_q;
    pend_x1_d    = pend_x1_q;
    pend_y1_d    = pend_y1_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    src_sel_d    = src_sel_q;
    req_d        = req_q;
    terr_d       = terr_q;
    timer_d      = timer_q;
    ack_s1_d     = bus.ack_tgl;
    ack_s_d      = ack_s1_q;

    consume0 = (state_q == LOAD) && !grant_q;
    consume1 = (state_q == LOAD) && grant_q;
    drop0    = bus.src0_valid && pend_q[0] && !consume0;
    drop1    = bus.src1_valid && pend_q[1] && !consume1;
    drop_sum = {1'b0, drop_q} + {8'd0, drop0} + {8'd0, drop1};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    // Clear before capture so a strobe landing on the LOAD of its own source stays pending.
    if (consume0) pend_d[0] = 1'b0;
    if (consume1) pend_d[1] = 1'b0;
    if (bus.src0_valid) begin
      pend_d[0] = 1'b1;
      pend_x0_d = bus.src0_x;
      pend_y0_d = bus.src0_y;
    end
    if (bus.src1_valid) begin
      pend_d[1] = 1'b1;
      pend_x1_d = bus.src1_x;
      pend_y1_d = bus.src1_y;
    end

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          grant_d = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];
          state_d = LOAD;
        end
      end
      LOAD: begin
        xpos_d       = grant_q ? pend_x1_q : pend_x0_q;
        ypos_d       = grant_q ? pend_y1_q : pend_y0_q;
        src_sel_d    = grant_q;
        last_grant_d = grant_q;
        state_d      = REQ;
      end
      REQ: begin
        req_d   = ~req_q;
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s_q == req_q) begin
          timer_d = '0;
          state_d = HOLD;
        end else if (timer_q == TIMEOUT_LAST) begin
          terr_d  = 1'b1;
          timer_d = '0;
          state_d = HOLD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD: begin
        if (timer_q == HOLD_LAST) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= 2'b00;
      pend_x0_q    <= '0;
      pend_y0_q    <= '0;
      pend_x1_q    <= '0;
      pend_y1_q    <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      xpos_q       <= '0;
      ypos_q       <= '0;
      src_sel_q    <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
      ack_s1_q     <= 1'b0;
      ack_s_q      <= 1'b0;
      timer_q      <= '0;
      drop_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_x0_q    <= pend_x0_d;
      pend_y0_q    <= pend_y0_d;
      pend_x1_q    <= pend_x1_d;
      pend_y1_q    <= pend_y1_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      src_sel_q    <= src_sel_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      terr_q       <= terr_d;
      ack_s1_q     <= ack_s1_d;
      ack_s_q      <= ack_s_d;
      timer_q      <= timer_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.req_tgl     = req_q;
  assign bus.xpos_out    = xpos_q;
  assign bus.ypos_out    = ypos_q;
  assign bus.src_sel     = src_sel_q;
  assign bus.busy        = busy_q;
  assign bus.drop_cnt    = drop_q;
  assign bus.timeout_err = terr_q;
endmodule
